// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and memory-side access signals
// for the unified-memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Requests are level: a requester holds *_req (with stable address/data) until its
  // one-cycle *_ready pulse. mem_en is a one-cycle strobe; the memory answers later
  // with a one-cycle mem_valid carrying mem_rdata in the same cycle.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ready;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;

  logic          bus_err;
  logic          stall_if;
  logic          stall_mem;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_valid, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, bus_err, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_valid, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, bus_err, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (I) and data access (D),
// with D priority, bounded I starvation, access timeout and dropping of flushed fetches.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  mem_port_arbiter_if.slave               bus,
  output logic [1:0]                      dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve_cnt
);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t         state_q, state_d;
  owner_t         owner_q;
  logic [SCW-1:0] starve_q;
  logic [WCW-1:0] wait_q, wait_inc;
  logic           drop_q, drop_eff;
  logic           grant_i, grant_d, starve_full;
  logic           resp_go, timeout_hit;
  logic [DW-1:0]  resp_data;

  logic           mem_en_q, mem_we_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q, if_rdata_q, d_rdata_q;
  logic           if_ready_q, d_ready_q, bus_err_q;

  always_comb begin
    state_d     = state_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    resp_go     = 1'b0;
    timeout_hit = 1'b0;
    starve_full = (starve_q == SCW'(STARVE_MAX));
    wait_inc    = wait_q + 1'b1;
    // A flush arriving in the same cycle as mem_valid must still suppress the fetch.
    drop_eff    = drop_q | bus.if_flush;
    resp_data   = bus.mem_valid ? bus.mem_rdata : '0;
    case (state_q)
      IDLE: begin
        grant_i = bus.if_req & (~bus.d_req | starve_full);
        grant_d = bus.d_req & ~grant_i;
        if (grant_i | grant_d) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.mem_valid) begin
          state_d = RESP;
          resp_go = 1'b1;
        end else if (wait_inc == WCW'(TIMEOUT)) begin
          state_d     = RESP;
          resp_go     = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_I;
      starve_q    <= '0;
      wait_q      <= '0;
      drop_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (grant_i) begin
            owner_q     <= OWN_I;
            mem_addr_q  <= bus.if_addr;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b1;
            starve_q    <= '0;
          end else if (grant_d) begin
            owner_q     <= OWN_D;
            mem_addr_q  <= bus.d_addr;
            mem_we_q    <= bus.d_we;
            mem_wdata_q <= bus.d_wdata;
            mem_en_q    <= 1'b1;
            if (!bus.if_req)      starve_q <= '0;
            else if (!starve_full) starve_q <= starve_q + 1'b1;
          end else begin
            starve_q <= '0;
          end
        end
        ISSUE: begin
          wait_q <= '0;
          if (owner_q == OWN_I && bus.if_flush) drop_q <= 1'b1;
        end
        WAIT: begin
          wait_q <= wait_inc;
          if (owner_q == OWN_I) begin
            drop_q <= drop_eff;
            if (resp_go && !drop_eff) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= resp_data;
              bus_err_q  <= timeout_hit;
            end
          end else if (resp_go) begin
            d_ready_q <= 1'b1;
            d_rdata_q <= resp_data;
            bus_err_q <= timeout_hit;
          end
        end
        RESP:    drop_q <= 1'b0;
        default: drop_q <= 1'b0;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.d_req & ~d_ready_q;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, D/I contention, starvation limit,
// flush drop, timeout and reset during an outstanding access.
module tb_mem_port_arbiter;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_starve_cnt;
  int          checks = 0;
  int          errors = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] mem_data = 32'h8C010004;
  int          kick_req = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(3), .TIMEOUT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (b.slave),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Memory model: valid one cycle after mem_en when auto, or one cycle after a kick.
  initial begin
    int   seen;
    logic pend;
    seen        = 0;
    b.mem_valid = 1'b0;
    b.mem_rdata = '0;
    forever begin
      @(negedge clk);
      pend = (b.mem_en === 1'b1 && mem_auto) || (kick_req != seen);
      seen = kick_req;
      @(posedge clk);
      #1;
      b.mem_valid = pend;
      b.mem_rdata = mem_data;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    mid();
    checks++;
    if (dbg_state !== S_IDLE || dbg_starve_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got state=%0d starve=%0d exp 0/0", dbg_state, dbg_starve_cnt);
    end
    checks++;
    if ({b.mem_en, b.mem_we, b.if_ready, b.d_ready, b.bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 00000",
               {b.mem_en, b.mem_we, b.if_ready, b.d_ready, b.bus_err});
    end
    checks++;
    if ({b.mem_addr, b.mem_wdata, b.if_rdata, b.d_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h exp all 0", b.mem_addr, b.mem_wdata, b.if_rdata, b.d_rdata);
    end
    step();
    rst = 1'b1;
    mid();
  endtask

  task automatic test_single_fetch();
    mem_auto = 1'b1;
    mem_data = 32'h8C010004;
    for (int c = 0; c <= 4; c++) begin
      step();
      if (c == 0) begin
        b.if_req  = 1'b1;
        b.if_addr = 32'h40;
      end
      if (c == 4) b.if_req = 1'b0;
      mid();
      if (c <= 2) begin
        checks++;
        if (b.stall_if !== 1'b1 || b.if_ready !== 1'b0) begin
          errors++;
          $display("FAIL fetch_stall c%0d got stall=%b ready=%b exp 1/0", c, b.stall_if, b.if_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (b.mem_en !== 1'b1 || b.mem_addr !== 32'h40 || b.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL fetch_issue got en=%b addr=%h we=%b exp 1/40/0", b.mem_en, b.mem_addr, b.mem_we);
        end
      end
      if (c == 3) begin
        checks++;
        if (b.if_ready !== 1'b1 || b.if_rdata !== 32'h8C010004 || b.stall_if !== 1'b0) begin
          errors++;
          $display("FAIL fetch_resp got ready=%b data=%h stall=%b exp 1/8c010004/0",
                   b.if_ready, b.if_rdata, b.stall_if);
        end
      end
      if (c == 4) begin
        checks++;
        if (dbg_state !== S_IDLE || b.if_ready !== 1'b0) begin
          errors++;
          $display("FAIL fetch_idle got state=%0d ready=%b exp 0/0", dbg_state, b.if_ready);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    mem_data = 32'h12345678;
    for (int c = 0; c <= 8; c++) begin
      step();
      if (c == 0) begin
        b.if_req  = 1'b1;
        b.if_addr = 32'h200;
        b.d_req   = 1'b1;
        b.d_we    = 1'b1;
        b.d_addr  = 32'h100;
        b.d_wdata = 32'hDEADBEEF;
      end
      if (c == 4) b.d_req = 1'b0;
      if (c == 8) b.if_req = 1'b0;
      mid();
      if (c == 0) begin
        checks++;
        if (b.stall_if !== 1'b1 || b.stall_mem !== 1'b1) begin
          errors++;
          $display("FAIL both_stall got if=%b mem=%b exp 1/1", b.stall_if, b.stall_mem);
        end
      end
      if (c == 1) begin
        checks++;
        if (b.mem_en !== 1'b1 || b.mem_we !== 1'b1 || b.mem_addr !== 32'h100 || b.mem_wdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL both_d_first got en=%b we=%b addr=%h wd=%h exp 1/1/100/deadbeef",
                   b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata);
        end
      end
      if (c == 3) begin
        checks++;
        if (b.d_ready !== 1'b1 || b.if_ready !== 1'b0 || b.stall_mem !== 1'b0) begin
          errors++;
          $display("FAIL both_d_ready got d=%b i=%b stall_mem=%b exp 1/0/0", b.d_ready, b.if_ready, b.stall_mem);
        end
      end
      if (c == 5) begin
        checks++;
        if (b.mem_en !== 1'b1 || b.mem_we !== 1'b0 || b.mem_addr !== 32'h200 || dbg_starve_cnt !== 2'd0) begin
          errors++;
          $display("FAIL both_i_second got en=%b we=%b addr=%h starve=%0d exp 1/0/200/0",
                   b.mem_en, b.mem_we, b.mem_addr, dbg_starve_cnt);
        end
      end
      if (c == 7) begin
        checks++;
        if (b.if_ready !== 1'b1 || b.if_rdata !== 32'h12345678) begin
          errors++;
          $display("FAIL both_i_ready got ready=%b data=%h exp 1/12345678", b.if_ready, b.if_rdata);
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] got;
    exp_q = '{32'h300, 32'h300, 32'h300, 32'h44};
    mem_data = 32'hA5A50001;
    for (int c = 0; c <= 16; c++) begin
      step();
      if (c == 0) begin
        b.if_req  = 1'b1;
        b.if_addr = 32'h44;
        b.d_req   = 1'b1;
        b.d_we    = 1'b0;
        b.d_addr  = 32'h300;
      end
      if (c == 16) begin
        b.if_req = 1'b0;
        b.d_req  = 1'b0;
      end
      mid();
      if (b.mem_en === 1'b1) obs_q.push_back(b.mem_addr);
      if (c == 12) begin
        checks++;
        if (dbg_starve_cnt !== 2'd3) begin
          errors++;
          $display("FAIL starve_full got %0d exp 3", dbg_starve_cnt);
        end
      end
      if (c == 13) begin
        checks++;
        if (dbg_starve_cnt !== 2'd0) begin
          errors++;
          $display("FAIL starve_clear got %0d exp 0", dbg_starve_cnt);
        end
      end
      if (c == 15) begin
        checks++;
        if (b.if_ready !== 1'b1 || b.if_rdata !== 32'hA5A50001) begin
          errors++;
          $display("FAIL starve_i_ready got ready=%b data=%h exp 1/a5a50001", b.if_ready, b.if_rdata);
        end
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL starve_grant_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++;
      if (got !== exp_q[0]) begin
        errors++;
        $display("FAIL starve_grant_order got %h exp %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_flush();
    int pulses;
    pulses   = 0;
    mem_auto = 1'b0;
    mem_data = 32'h00A00093;
    for (int c = 0; c <= 10; c++) begin
      step();
      if (c == 0) begin
        b.if_req  = 1'b1;
        b.if_addr = 32'h80;
      end
      if (c == 2) b.if_flush = 1'b1;
      if (c == 3) begin
        b.if_flush = 1'b0;
        b.if_addr  = 32'h90;
        kick_req++;
      end
      if (c == 6) mem_auto = 1'b1;
      if (c == 10) b.if_req = 1'b0;
      mid();
      if (c <= 6 && (b.if_ready === 1'b1 || b.bus_err === 1'b1)) pulses++;
      if (c == 5) begin
        checks++;
        if (dbg_state !== S_RESP || b.stall_if !== 1'b1) begin
          errors++;
          $display("FAIL flush_resp got state=%0d stall=%b exp 3/1", dbg_state, b.stall_if);
        end
      end
      if (c == 6) begin
        checks++;
        if (dbg_state !== S_IDLE) begin
          errors++;
          $display("FAIL flush_idle got state=%0d exp 0", dbg_state);
        end
      end
      if (c == 7) begin
        checks++;
        if (b.mem_en !== 1'b1 || b.mem_addr !== 32'h90) begin
          errors++;
          $display("FAIL flush_refetch got en=%b addr=%h exp 1/90", b.mem_en, b.mem_addr);
        end
      end
      if (c == 9) begin
        checks++;
        if (b.if_ready !== 1'b1 || b.if_rdata !== 32'h00A00093) begin
          errors++;
          $display("FAIL flush_refetch_ready got ready=%b data=%h exp 1/00a00093", b.if_ready, b.if_rdata);
        end
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_dropped got %0d ready/err pulses exp 0", pulses);
    end
  endtask

  task automatic test_timeout();
    int          waits;
    int          cyc_at;
    bit          seen;
    logic        err_at;
    logic        iready_at;
    logic [31:0] rdata_at;
    waits     = 0;
    cyc_at    = -1;
    seen      = 1'b0;
    err_at    = 1'b0;
    iready_at = 1'b0;
    rdata_at  = 32'hFFFFFFFF;
    mem_auto  = 1'b0;
    mem_data  = 32'h55AA55AA;
    step();
    b.d_req  = 1'b1;
    b.d_we   = 1'b0;
    b.d_addr = 32'h500;
    mid();
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      mid();
      if (dbg_state === S_WAIT) waits++;
      if (b.d_ready === 1'b1) begin
        seen      = 1'b1;
        cyc_at    = c;
        err_at    = b.bus_err;
        iready_at = b.if_ready;
        rdata_at  = b.d_rdata;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_bound got no d_ready in 40 cycles exp d_ready");
    end
    checks++;
    if (cyc_at != 17 || waits != 15) begin
      errors++;
      $display("FAIL timeout_latency got cycle=%0d waits=%0d exp 17/15", cyc_at, waits);
    end
    checks++;
    if (err_at !== 1'b1 || rdata_at !== 32'h0 || iready_at !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp got err=%b rdata=%h if_ready=%b exp 1/0/0", err_at, rdata_at, iready_at);
    end
    step();
    b.d_req = 1'b0;
    mid();
    checks++;
    if (b.bus_err !== 1'b0 || b.d_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_single_pulse got err=%b ready=%b exp 0/0", b.bus_err, b.d_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    pulses   = 0;
    mem_auto = 1'b0;
    mem_data = 32'hCAFEF00D;
    for (int c = 0; c <= 8; c++) begin
      step();
      if (c == 0) begin
        b.d_req   = 1'b1;
        b.d_we    = 1'b1;
        b.d_addr  = 32'h600;
        b.d_wdata = 32'h0BADCAFE;
      end
      if (c == 3) begin
        rst     = 1'b0;
        b.d_req = 1'b0;
      end
      if (c == 4) begin
        rst = 1'b1;
        kick_req++;
      end
      mid();
      if (c == 2) begin
        checks++;
        if (dbg_state !== S_WAIT) begin
          errors++;
          $display("FAIL rstwait_in_wait got state=%0d exp 2", dbg_state);
        end
      end
      if (c == 4) begin
        checks++;
        if (dbg_state !== S_IDLE || {b.mem_en, b.mem_we, b.if_ready, b.d_ready, b.bus_err} !== 5'b0 ||
            {b.mem_addr, b.mem_wdata, b.if_rdata, b.d_rdata} !== 128'd0) begin
          errors++;
          $display("FAIL rstwait_cleared got state=%0d strobes=%b addr=%h wd=%h ir=%h dr=%h exp all 0",
                   dbg_state, {b.mem_en, b.mem_we, b.if_ready, b.d_ready, b.bus_err},
                   b.mem_addr, b.mem_wdata, b.if_rdata, b.d_rdata);
        end
      end
      if (c >= 5 && (b.if_ready === 1'b1 || b.d_ready === 1'b1 || b.bus_err === 1'b1 ||
                     b.mem_en === 1'b1 || dbg_state !== S_IDLE)) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rstwait_stale_valid got %0d active cycles exp 0", pulses);
    end
    mem_auto = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst        = 1'b0;
    b.if_req   = 1'b0;
    b.if_addr  = '0;
    b.if_flush = 1'b0;
    b.d_req    = 1'b0;
    b.d_we     = 1'b0;
    b.d_addr   = '0;
    b.d_wdata  = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
